button_counter: RTL and testbench

BUTTON_COUNTER -- requirements
Module: button_counter

---
 rtl/button_counter.sv | 189 ++++++++++++++++++
 tb/tb_button_counter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_counter.sv
// Two-button up/down counter with sync, debounce and hold-to-repeat per button.
// Define BCD_MODE_EN for decimal digits (0-9 per nibble); default is plain binary.
module button_counter #(
    parameter int DIGITS          = 4,
    parameter int FREQ            = 27_000_000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_up_button,
    input  logic                  i_down_button,
    output logic [4*DIGITS-1:0]   o_number,
    output logic                  o_step
);

    localparam int DB_TICKS = FREQ / 1000 * DEBOUNCE_MS;
    localparam int RD_TICKS = FREQ / 1000 * REPEAT_DELAY_MS;
    localparam int RR_TICKS = FREQ / 1000 * REPEAT_RATE_MS;
    localparam int NW       = 4 * DIGITS;
    localparam int DBW      = $clog2(DB_TICKS + 1);
    localparam int TMR_MAX  = (RD_TICKS > RR_TICKS) ? RD_TICKS : RR_TICKS;
    localparam int TW       = $clog2(TMR_MAX + 1);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);
    localparam logic [TW-1:0]  RD_LAST = TW'(RD_TICKS - 1);
    localparam logic [TW-1:0]  RR_LAST = TW'(RR_TICKS - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_e;

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]     raw_n;
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     pressed_q, pressed_d;
    logic [1:0]     other_pressed;
    logic [DBW-1:0] db_cnt_q [2];
    logic [DBW-1:0] db_cnt_d [2];
    state_e         state_q  [2];
    state_e         state_d  [2];
    logic [TW-1:0]  tmr_q    [2];
    logic [TW-1:0]  tmr_d    [2];
    logic [1:0]     step_req;
    logic [NW-1:0]  number_q, number_d;
    logic           step_q, step_d;

    assign raw_n         = {i_down_button, i_up_button};
    assign other_pressed = {pressed_q[0], pressed_q[1]};

`ifdef BCD_MODE_EN
    function automatic logic [NW-1:0] num_inc(input logic [NW-1:0] v);
        logic [NW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (v[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [NW-1:0] num_dec(input logic [NW-1:0] v);
        logic [NW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (borrow) begin
                if (v[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction
`else
    function automatic logic [NW-1:0] num_inc(input logic [NW-1:0] v);
        return v + NW'(1);
    endfunction

    function automatic logic [NW-1:0] num_dec(input logic [NW-1:0] v);
        return v - NW'(1);
    endfunction
`endif

    // Debounce: flip only after DB_TICKS consecutive disagreeing samples.
    always_comb begin
        pressed_d = pressed_q;
        for (int b = 0; b < 2; b++) begin
            db_cnt_d[b] = '0;
            if (sync2_q[b] == pressed_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    pressed_d[b] = ~pressed_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DBW'(1);
                end
            end
        end
    end

    // Both pressed parks both FSMs in HELD with cleared timers and no steps.
    always_comb begin
        step_req = '0;
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            tmr_d[b]   = '0;
            if (!pressed_q[b]) begin
                state_d[b] = IDLE;
            end else if (other_pressed[b]) begin
                state_d[b] = HELD;
            end else begin
                case (state_q[b])
                    IDLE: begin
                        state_d[b]  = HELD;
                        step_req[b] = 1'b1;
                    end
                    HELD: begin
                        if (tmr_q[b] == RD_LAST) begin
                            state_d[b]  = REPEAT;
                            step_req[b] = 1'b1;
                        end else begin
                            tmr_d[b] = tmr_q[b] + TW'(1);
                        end
                    end
                    REPEAT: begin
                        if (tmr_q[b] == RR_LAST) begin
                            step_req[b] = 1'b1;
                        end else begin
                            tmr_d[b] = tmr_q[b] + TW'(1);
                        end
                    end
                    default: state_d[b] = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        number_d = number_q;
        step_d   = 1'b0;
        if (step_req[0]) begin
            number_d = num_inc(number_q);
            step_d   = 1'b1;
        end else if (step_req[1]) begin
            number_d = num_dec(number_q);
            step_d   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            pressed_q <= 2'b00;
            number_q  <= '0;
            step_q    <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= '0;
                state_q[b]  <= IDLE;
                tmr_q[b]    <= '0;
            end
        end else begin
            sync1_q   <= raw_n;
            sync2_q   <= sync1_q;
            pressed_q <= pressed_d;
            number_q  <= number_d;
            step_q    <= step_d;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= db_cnt_d[b];
                state_q[b]  <= state_d[b];
                tmr_q[b]    <= tmr_d[b];
            end
        end
    end

    assign o_number = number_q;
    assign o_step   = step_q;

endmodule

// File: tb/tb_button_counter.sv
// Randomized and directed bench for button_counter with a cycle-level reference model.
// Honours BCD_MODE_EN the same way as the design.
module tb_button_counter;

    localparam int DIGITS = 4;
    localparam int FREQ   = 1000;
    localparam int DB_T   = 4;
    localparam int RD_T   = 20;
    localparam int RR_T   = 5;
    localparam int NW     = 4 * DIGITS;
`ifdef BCD_MODE_EN
    localparam int MODV = 10000;
    localparam logic [NW-1:0] MAX_NUM = 16'h9999;
    localparam logic [NW-1:0] TEN_NUM = 16'h0010;
`else
    localparam int MODV = 65536;
    localparam logic [NW-1:0] MAX_NUM = 16'hFFFF;
    localparam logic [NW-1:0] TEN_NUM = 16'h000A;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          up_n  = 1'b1;
    logic          dn_n  = 1'b1;
    logic [NW-1:0] number;
    logic          step;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [47:0] exp_q[$];
    int          step_log[$];

    button_counter #(
        .DIGITS(DIGITS), .FREQ(FREQ), .DEBOUNCE_MS(4),
        .REPEAT_DELAY_MS(20), .REPEAT_RATE_MS(5)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_up_button(up_n),
        .i_down_button(dn_n), .o_number(number), .o_step(step)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [NW-1:0] enc(input int v);
        logic [NW-1:0] r;
        int t;
        r = '0;
        t = v;
`ifdef BCD_MODE_EN
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
`else
        r = NW'(t);
`endif
        return r;
    endfunction

    // Reference model: value as an integer, per-button "solo hold age".
    bit [1:0] m_s1, m_s2, m_db, m_act;
    int       m_run[2];
    int       m_age[2];
    int       m_val;

    always @(posedge clk) begin
        bit [1:0] db_old;
        bit [1:0] stp;
        cyc++;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_act = '0; m_val = 0;
            for (int b = 0; b < 2; b++) begin m_run[b] = 0; m_age[b] = 0; end
            exp_q.delete();
        end else begin
            db_old = m_db;
            stp    = '0;
            for (int b = 0; b < 2; b++) begin
                if (db_old[b] && !db_old[b ^ 1]) begin
                    if (!m_act[b]) begin
                        stp[b]   = 1'b1;
                        m_age[b] = 0;
                    end else begin
                        m_age[b]++;
                        if (m_age[b] >= RD_T && (m_age[b] - RD_T) % RR_T == 0) stp[b] = 1'b1;
                    end
                    m_act[b] = 1'b1;
                end else if (db_old[b]) begin
                    m_act[b] = 1'b1;
                    m_age[b] = 0;
                end else begin
                    m_act[b] = 1'b0;
                    m_age[b] = 0;
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (m_s2[b] != m_db[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB_T) begin
                        m_db[b]  = ~m_db[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {!dn_n, !up_n};
            if (stp[0]) m_val = (m_val + 1) % MODV;
            else if (stp[1]) m_val = (m_val + MODV - 1) % MODV;
            if (stp != 2'b00) exp_q.push_back({32'(cyc), enc(m_val)});
        end
    end

    // Monitor: pops one expectation per DUT step, otherwise the value must hold.
    logic [NW-1:0] last_num = '0;
    always @(negedge clk) begin
        logic [47:0] e;
        if (!rst_n) begin
            last_num = '0;
        end else if (step) begin
            check("step_queue_depth", 48'(exp_q.size()), 48'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("step_cycle", 48'(cyc), 48'(e[47:16]));
                check("step_number", 48'(number), 48'(e[15:0]));
                last_num = e[15:0];
            end
            step_log.push_back(cyc);
        end else begin
            check("missed_step", 48'(exp_q.size()), 48'd0);
            check("hold_number", 48'(number), 48'(last_num));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("reset_number", 48'(number), 48'd0);
        check("reset_step", 48'(step), 48'd0);
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic check_log(input string name, input int base, input int idx, input int offs);
        if (step_log.size() > idx) check(name, 48'(step_log[idx] - base), 48'(offs));
        else check({name, "_missing"}, 48'(step_log.size()), 48'(idx + 1));
    endtask

    task automatic tap(input bit is_up);
        if (is_up) up_n = 1'b0; else dn_n = 1'b0;
        tick(10);
        up_n = 1'b1;
        dn_n = 1'b1;
        tick(15);
    endtask

    initial begin
        int p;
        tick(1);
        apply_reset();
        tick(3);

        // Short glitch: filtered out.
        step_log.delete();
        up_n = 1'b0; tick(3); up_n = 1'b1; tick(20);
        check("glitch_steps", 48'(step_log.size()), 48'd0);
        check("glitch_number", 48'(number), 48'(enc(0)));

        // Single press: step 7 cycles after the press.
        step_log.delete();
        p = cyc;
        up_n = 1'b0; tick(10); up_n = 1'b1; tick(15);
        check("single_steps", 48'(step_log.size()), 48'd1);
        check_log("single_latency", p, 0, 7);
        check("single_number", 48'(number), 48'(enc(1)));

        // Held: initial step, delayed repeat, then repeat rate.
        apply_reset();
        tick(2);
        step_log.delete();
        p = cyc;
        up_n = 1'b0; tick(35); up_n = 1'b1; tick(15);
        check("hold_steps", 48'(step_log.size()), 48'd4);
        check_log("hold_step0", p, 0, 7);
        check_log("hold_step1", p, 1, 27);
        check_log("hold_step2", p, 2, 32);
        check_log("hold_step3", p, 3, 37);
        check("hold_number_final", 48'(number), 48'(enc(4)));

        // Wrap-around and digit rollover.
        apply_reset();
        tick(2);
        tap(1'b0);
        check("wrap_down", 48'(number), 48'(MAX_NUM));
        tap(1'b1);
        check("wrap_up", 48'(number), 48'(enc(0)));
        for (int i = 0; i < 9; i++) tap(1'b1);
        check("nine", 48'(number), 48'(enc(9)));
        tap(1'b1);
        check("nine_plus_one", 48'(number), 48'(TEN_NUM));

        // Both pressed: silent; survivor repeats RD after the other's debounced release.
        apply_reset();
        tick(2);
        step_log.delete();
        up_n = 1'b0; dn_n = 1'b0;
        tick(30);
        up_n = 1'b1;
        p = cyc;
        tick(40);
        dn_n = 1'b1;
        tick(15);
        check_log("both_first_repeat", p, 0, 6 + RD_T);

        // Reset during repeat aborts; held button is a fresh press afterwards.
        apply_reset();
        tick(2);
        p = cyc;
        up_n = 1'b0;
        tick(33);
        check("pre_reset_number", 48'(number), 48'(enc(3)));
        apply_reset();
        p = cyc;
        step_log.delete();
        tick(15);
        up_n = 1'b1;
        tick(15);
        check("post_reset_steps", 48'(step_log.size()), 48'd1);
        check_log("post_reset_latency", p, 0, 7);
        check("post_reset_number", 48'(number), 48'(enc(1)));

        // Random traffic, occasional resets.
        for (int i = 0; i < 90; i++) begin
            up_n = 1'($urandom_range(0, 1));
            dn_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) apply_reset();
            tick($urandom_range(1, 40));
        end
        up_n = 1'b1;
        dn_n = 1'b1;
        tick(30);
        check("queue_drained", 48'(exp_q.size()), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
